// File: rtl/apb_pkg.sv
// Shared definitions for the APB register-file slave: FSM states, register map
// constants and address-decode helpers.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } apb_state_e;

    localparam logic [7:0] STATUS_ADDR = 8'h0E;
    localparam logic [7:0] ID_ADDR     = 8'h0F;
    localparam int         NUM_RW      = 14;
    localparam logic [7:0] ID_DEFAULT  = 8'hA5;
    localparam int         CNT_W       = 4;

    function automatic logic is_rw_addr(input logic [7:0] addr);
        return addr < 8'(NUM_RW);
    endfunction

    // Unmapped space errors on any access; the two read-only registers error on writes.
    function automatic logic is_err(input logic [7:0] addr, input logic write);
        return (addr > ID_ADDR) || (write && (addr == STATUS_ADDR || addr == ID_ADDR));
    endfunction

endpackage

// File: rtl/apb_wait_counter.sv
// Wait-state down-counter: loads a count, decrements on request, and flags the
// last wait cycle (count == 1) so the FSM can enter RESP on that edge.
module apb_wait_counter
    import apb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/apb_slave_regfile.sv
// APB slave with 14 RW byte registers, a completed-transfer counter (STATUS) and
// a constant ID register; programmable wait states, fully registered response.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [7:0]  ID_VALUE    = ID_DEFAULT
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       PSELx,
    input  logic       PENABLE,
    input  logic       PWRITE,
    input  logic [7:0] PADDR,
    input  logic [7:0] PWDATA,
    output logic [7:0] PRDATA,
    output logic       PREADY,
    output logic       PSLVERR
);

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

    apb_state_e state_q, state_d;
    logic       pready_q, pready_d;
    logic       pslverr_q, pslverr_d;
    logic [7:0] prdata_q, prdata_d;
    logic [7:0] status_q, status_d;
    logic [7:0] regs_q [NUM_RW];
    logic [7:0] regs_d [NUM_RW];

    logic       setup, access, start;
    logic       cnt_load, cnt_dec, cnt_tc;
    logic       enter_resp, access_err, commit;
    logic [7:0] rd_data;

    assign setup      = PSELx & ~PENABLE;
    assign access     = PSELx & PENABLE;
    assign access_err = is_err(PADDR, PWRITE);

    apb_wait_counter u_wait_counter (
        .clk      (PCLK),
        .rst_n    (PRESETn),
        .load     (cnt_load),
        .load_val (WAIT_LOAD),
        .dec      (cnt_dec),
        .tc       (cnt_tc)
    );

    always_comb begin
        rd_data = 8'h00;
        if (PADDR == ID_ADDR) begin
            rd_data = ID_VALUE;
        end else if (PADDR == STATUS_ADDR) begin
            rd_data = status_q;
        end else if (is_rw_addr(PADDR)) begin
            rd_data = regs_q[PADDR[3:0]];
        end
    end

    // Next-state logic; a setup phase in RESP starts a new transfer just as in IDLE.
    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        start    = 1'b0;
        unique case (state_q)
            ST_IDLE: start = setup;
            ST_WAIT: begin
                if (!PSELx) begin
                    state_d = ST_IDLE;
                end else if (access) begin
                    cnt_dec = 1'b1;
                    if (cnt_tc) begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                start   = setup;
            end
            default: state_d = ST_IDLE;
        endcase
        if (start) begin
            if (WAIT_CYCLES == 0) begin
                state_d = ST_RESP;
            end else begin
                state_d  = ST_WAIT;
                cnt_load = 1'b1;
            end
        end
    end

    // Outputs are loaded on RESP entry and cleared otherwise; state commits at RESP exit.
    always_comb begin
        enter_resp = (state_d == ST_RESP);
        pready_d   = enter_resp;
        pslverr_d  = enter_resp & access_err;
        prdata_d   = (enter_resp && !PWRITE && !access_err) ? rd_data : 8'h00;
        commit     = (state_q == ST_RESP) && access && !pslverr_q;
        status_d   = status_q;
        regs_d     = regs_q;
        if (commit) begin
            status_d = status_q + 8'd1;
            if (PWRITE) begin
                regs_d[PADDR[3:0]] = PWDATA;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q   <= ST_IDLE;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= 8'h00;
            status_q  <= 8'h00;
            // NOTE: the register array is small and must read back 0 after reset, so it is reset like ordinary flops.
            regs_q    <= '{default: 8'h00};
        end else begin
            state_q   <= state_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            status_q  <= status_d;
            regs_q    <= regs_d;
        end
    end

    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;
    assign PRDATA  = prdata_q;

endmodule

// File: doc/apb_slave_regfile.md
APB_SLAVE_REGFILE -- requirements
Module: apb_slave_regfile

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, number of ACCESS cycles with PREADY low before completion (0..15).
REQ-002 SHALL have parameter ID_VALUE, default 8'hA5, constant returned by the ID register.
REQ-003 SHALL have PCLK  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have PRESETn  input  1  reset, synchronous and active-low.
REQ-005 SHALL have PSELx  input  1  slave select from APB master.
REQ-006 SHALL have PENABLE  input  1  access phase indicator.
REQ-007 SHALL have PWRITE  input  1  1 = write, 0 = read.
REQ-008 SHALL have PADDR  input  8  byte address.
REQ-009 SHALL have PWDATA  input  8  write data.
REQ-010 SHALL have PRDATA  output  8  read data, valid only while PREADY=1 on a read.
REQ-011 SHALL have PREADY  output  1  transfer completion.
REQ-012 SHALL have PSLVERR  output  1  error response, valid only while PREADY=1.

Function
REQ-013 Map: 0x00-0x0D RW data registers; 0x0E STATUS (RO); 0x0F ID (RO, ID_VALUE); 0x10-0xFF unmapped.
REQ-014 FSM states IDLE, WAIT, RESP; PREADY, PRDATA, PSLVERR all registered.
REQ-015 IDLE: PSELx=1 & PENABLE=0 (setup) -> WAIT with counter loaded to WAIT_CYCLES if WAIT_CYCLES>0, else -> RESP.
REQ-016 WAIT: counter decrements each cycle PSELx=1 & PENABLE=1; on the cycle it reaches 1, next state RESP.
REQ-017 Entering RESP: PREADY<=1, PSLVERR and PRDATA driven; hence WAIT_CYCLES=N gives exactly N ACCESS cycles with PREADY=0, then one with PREADY=1.
REQ-018 RESP lasts one cycle: PREADY<=0, PRDATA<=0, PSLVERR<=0, -> IDLE; a setup phase seen in RESP is processed as in IDLE.
REQ-019 Write commits at the rising edge ending the RESP cycle, only if PSELx=1 & PENABLE=1 & PWRITE=1 & PSLVERR=0.
REQ-020 Read data = register addressed by PADDR sampled at the RESP-entry edge; unmapped or error read returns 8'h00.
REQ-021 PSLVERR=1 for any unmapped address, and for writes to 0x0E or 0x0F; errored writes change no state.
REQ-022 STATUS = 8-bit count of completed non-error transfers, +1 at end of each RESP with PSLVERR=0, wraps 0xFF->0x00; a read of 0x0E returns the value before its own increment.
REQ-023 Back-to-back write then read of the same address returns the newly written value.
REQ-024 PSELx dropping to 0 in WAIT or RESP aborts: no write, no STATUS increment, PREADY<=0, -> IDLE.
REQ-025 PENABLE=1 seen in IDLE without a preceding setup is ignored (no response).

Reset
REQ-026 PRESETn=0 at a rising edge SHALL force IDLE, counter 0, PREADY=0, PSLVERR=0, PRDATA=8'h00, all RW registers 8'h00, STATUS 8'h00.
REQ-027 Reset mid-transfer SHALL discard the transfer with no register write; the first setup after release is served normally.

Structure
REQ-028 Shared package apb_pkg SHALL hold the FSM state typedef, register address constants (STATUS_ADDR=8'h0E, ID_ADDR=8'h0F, NUM_RW=14) and the default ID value.
REQ-029 Wait-state counting SHALL be a sub-module apb_wait_counter (load, decrement, terminal-count flag).

Verification
REQ-030 WAIT_CYCLES=1: write 0x3C to 0x05, then read 0x05 -> each transfer one PREADY=0 access cycle, then PREADY=1; read PRDATA=0x3C, PSLVERR=0.
REQ-031 WAIT_CYCLES=0 and 3: read 0x0F -> PREADY=1 in first access cycle, or after exactly 3 wait cycles; PRDATA=0xA5.
REQ-032 Write 0x77 to 0x0F and read 0x20 -> PSLVERR=1 on both, read PRDATA=0x00, ID unchanged, STATUS unchanged.
REQ-033 Perform 256 good transfers then read 0x0E -> STATUS=0x00 (wrap); after one more read of 0x0E -> 0x01.
REQ-034 Deassert PSELx during WAIT of a write of 0x99 to 0x02 -> 0x02 stays 0x00, PREADY never asserted, STATUS unchanged.
REQ-035 Assert PRESETn=0 during WAIT of a write to 0x03 -> next cycle PREADY=0, all registers 0x00; subsequent read 0x03 returns 0x00.
